// File: rtl/sm4_sbox_tau_seq.sv
// SM4 non-linear transform tau: every byte of a LANES-byte word goes through the
// SM4 S-box, SBOX_NUM lanes per cycle, with valid/ready on both sides.
module sm4_sbox_tau_seq #(
    parameter int LANES    = 4,
    parameter int SBOX_NUM = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] result_out,
    output logic               busy
);

    localparam int SN_SAFE = (SBOX_NUM < 1) ? 1 : SBOX_NUM;
    localparam int STEPS_R = LANES / SN_SAFE;
    localparam int STEPS   = (STEPS_R < 1) ? 1 : STEPS_R;
    localparam int CNT_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int GRP_W   = 8 * SN_SAFE;

    if (LANES < 1 || SBOX_NUM < 1 || (LANES % SN_SAFE) != 0) begin : g_param_err
        $error("sm4_sbox_tau_seq: SBOX_NUM must be >= 1 and divide LANES >= 1");
    end

    // S(x) sits at bits [2047-8x -: 8]; row-major, S(00) in the top byte.
    localparam logic [2047:0] SBOX_TAB = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TAB[2047 - 8*int'(b) -: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [8*LANES-1:0] work_q, work_d;
    logic [GRP_W-1:0]   grp_in, grp_sub;
    logic               last_step;
    logic               accept;

    assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == SUB);
    assign result_out = work_q;
    assign accept     = in_valid && in_ready;
    assign last_step  = (cnt_q == CNT_W'(STEPS - 1));

    // Only the lane group selected by the step counter is looked up each cycle.
    always_comb begin
        grp_in  = work_q[int'(cnt_q)*GRP_W +: GRP_W];
        grp_sub = '0;
        for (int j = 0; j < SN_SAFE; j++) begin
            grp_sub[j*8 +: 8] = sbox(grp_in[j*8 +: 8]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d  = data_in;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                work_d[int'(cnt_q)*GRP_W +: GRP_W] = grp_sub;
                if (last_step) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = data_in;
                        cnt_d   = '0;
                        state_d = SUB;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

endmodule

// File: tb/tb_sm4_sbox_tau_seq.sv
// Directed and table-model bench for sm4_sbox_tau_seq in three configurations:
// default (4,1), single-cycle (4,4) and wide (16,2).
module tb_sm4_sbox_tau_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         iv_a, ir_a, ov_a, or_a, busy_a;
    logic [31:0]  d_a, r_a;
    logic         iv_b, ir_b, ov_b, or_b, busy_b;
    logic [31:0]  d_b, r_b;
    logic         iv_c, ir_c, ov_c, or_c, busy_c;
    logic [127:0] d_c, r_c;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [2047:0] SBT = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    sm4_sbox_tau_seq #(.LANES(4), .SBOX_NUM(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .data_in(d_a),
        .out_valid(ov_a), .out_ready(or_a), .result_out(r_a), .busy(busy_a));

    sm4_sbox_tau_seq #(.LANES(4), .SBOX_NUM(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .data_in(d_b),
        .out_valid(ov_b), .out_ready(or_b), .result_out(r_b), .busy(busy_b));

    sm4_sbox_tau_seq #(.LANES(16), .SBOX_NUM(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .data_in(d_c),
        .out_valid(ov_c), .out_ready(or_c), .result_out(r_c), .busy(busy_c));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] tau_ref(input logic [127:0] w, input int lanes);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < lanes; k++) begin
            r[k*8 +: 8] = SBT[2047 - 8*int'(w[k*8 +: 8]) -: 8];
        end
        return r;
    endfunction

    // Called #1 after the accepting edge; counts edges until out_valid and busy samples.
    task automatic wait_out_a(output int lat, output int bc);
        lat = 0;
        bc  = busy_a ? 1 : 0;
        while (!ov_a && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy_a) bc++;
        end
    endtask

    task automatic xact_a(input logic [31:0] d, input logic [31:0] exp, input string tag);
        int lat, bc;
        d_a = d; iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        wait_out_a(lat, bc);
        check_eq({tag, "_lat"}, lat, 4);
        check_eq(tag, r_a, exp);
        @(posedge clk); #1;
    endtask

    task automatic xact_b(input logic [31:0] d, input logic [31:0] exp, input string tag);
        int lat;
        lat = 0;
        d_b = d; iv_b = 1'b1;
        @(posedge clk); #1;
        iv_b = 1'b0;
        while (!ov_b && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 1);
        check_eq(tag, r_b, exp);
        @(posedge clk); #1;
    endtask

    task automatic xact_c(input logic [127:0] d, input logic [127:0] exp, input string tag);
        int lat;
        lat = 0;
        d_c = d; iv_c = 1'b1;
        @(posedge clk); #1;
        iv_c = 1'b0;
        while (!ov_c && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 8);
        check_eq(tag, r_c, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, bc, t1, t2, seen_ov, distinct;
        logic [31:0]  w32;
        logic [127:0] w128;
        logic         seen [256];

        rst_n = 1'b0;
        iv_a = 1'b0; d_a = '0; or_a = 1'b1;
        iv_b = 1'b0; d_b = '0; or_b = 1'b1;
        iv_c = 1'b0; d_c = '0; or_c = 1'b1;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;

        #12;
        check_eq("rst_in_ready", ir_a, 1);
        check_eq("rst_out_valid", ov_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_result", r_a, 0);
        check_eq("rst_b_c", {ov_b, busy_b, r_b, ov_c, busy_c, r_c}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_in_ready", ir_a, 1);

        // single word, out_ready high
        d_a = 32'h03020100; iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        wait_out_a(lat, bc);
        check_eq("a_lat", lat, 4);
        check_eq("a_busy_cycles", bc, 4);
        check_eq("a_result", r_a, 32'hfee990d6);
        check_eq("a_in_ready_done", ir_a, 1);
        @(posedge clk); #1;
        check_eq("a_ov_after", ov_a, 0);
        check_eq("a_idle_ready", ir_a, 1);

        // stalled output
        or_a = 1'b0;
        d_a = 32'hab71ff10; iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        wait_out_a(lat, bc);
        check_eq("stall_lat", lat, 4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("stall_result", r_a, 32'hab00482b);
            check_eq("stall_ov", ov_a, 1);
            check_eq("stall_in_ready", ir_a, 0);
        end
        or_a = 1'b1;
        #1;
        check_eq("stall_release_ready", ir_a, 1);
        @(posedge clk); #1;
        check_eq("stall_released", ov_a, 0);

        // back-to-back; the second word is presented during SUB and must wait
        d_a = 32'h00000000; iv_a = 1'b1;
        @(posedge clk); #1;
        d_a = 32'hffffffff;
        wait_out_a(lat, bc);
        t1 = cyc;
        check_eq("b2b_lat1", lat, 4);
        check_eq("b2b_res1", r_a, 32'hd6d6d6d6);
        check_eq("b2b_ready1", ir_a, 1);
        @(posedge clk); #1;
        iv_a = 1'b0;
        check_eq("b2b_accept2", busy_a, 1);
        wait_out_a(lat, bc);
        t2 = cyc;
        check_eq("b2b_res2", r_a, 32'h48484848);
        check_eq("b2b_spacing", t2 - t1, 5);
        @(posedge clk); #1;

        // reset in the middle of SUB
        d_a = 32'h01010101; iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_ov", ov_a, 0);
        check_eq("mrst_busy", busy_a, 0);
        check_eq("mrst_result", r_a, 0);
        check_eq("mrst_ready", ir_a, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_ov = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ov_a || busy_a) seen_ov++;
        end
        check_eq("mrst_no_output", seen_ov, 0);
        check_eq("mrst_ready_after", ir_a, 1);
        xact_a(32'h02020202, 32'he9e9e9e9, "post_rst");

        // default config: every byte value in every lane
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) w32[k*8 +: 8] = 8'(i) ^ 8'(k * 85);
            xact_a(w32, 32'(tau_ref({96'd0, w32}, 4)), "cov_a");
        end

        // single-step configuration
        xact_b(32'h03020100, 32'hfee990d6, "b_directed");
        xact_b(32'hab71ff10, 32'hab00482b, "b_examples");
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) w32[k*8 +: 8] = 8'(i + 64 * k);
            xact_b(w32, 32'(tau_ref({96'd0, w32}, 4)), "cov_b");
            seen[r_b[7:0]] = 1'b1;
        end
        distinct = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
        check_eq("b_sbox_bijective", distinct, 256);
        for (int i = 0; i < 768; i++) begin
            w32 = $urandom;
            xact_b(w32, 32'(tau_ref({96'd0, w32}, 4)), "rnd_b");
        end

        // wide configuration
        xact_c(128'h0f0e0d0c0b0a09080706050403020100,
               128'h052cfb28c214b616b73de1ccfee990d6, "c_directed");
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 16; k++) w128[k*8 +: 8] = 8'(i + 16 * k);
            xact_c(w128, tau_ref(w128, 16), "cov_c");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
